// File: rtl/fir_tdm_mac.sv
// Channel-multiplexed serial FIR: one multiplier, per-channel circular delay lines,
// shared writable coefficient bank, round-half-up and saturating output stage.
module fir_tdm_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 64,
    parameter int CH        = 2,
    parameter int OUT_SHIFT = 15,
    localparam int CH_W     = (CH > 1) ? $clog2(CH) : 1,
    localparam int TAP_W    = $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     coef_we,
    input  logic [TAP_W-1:0]         coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_sat,
    output logic                     busy
);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + TAP_W;
    localparam logic [TAP_W-1:0] LAST_K = TAP_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (OUT_SHIFT - 1);

    typedef enum logic {IDLE, MAC} state_t;
    state_t state, state_next;

    logic signed [COEF_W-1:0] coef  [TAPS];
    logic signed [DATA_W-1:0] delay [CH][TAPS];
    logic        [TAP_W-1:0]  wr_ptr [CH];
    logic        [CH_W-1:0]   ch;
    logic        [TAP_W-1:0]  k;
    logic signed [ACC_W-1:0]  acc;

    logic                     ch_ok;
    logic                     accept;
    logic                     last;
    logic        [TAP_W-1:0]  wr_next;
    logic        [TAP_W-1:0]  rd_ptr;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  mac_sum;
    logic signed [ACC_W-1:0]  rounded;
    logic signed [ACC_W-1:0]  shifted;
    logic                     sat;
    logic signed [DATA_W-1:0] result;

    // A channel field that exactly fills its width can never be out of range.
    generate
        if (CH == (1 << CH_W)) begin : g_ch_full
            assign ch_ok = 1'b1;
        end else begin : g_ch_part
            assign ch_ok = (in_ch < CH_W'(CH));
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (last)   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
    end

    assign accept  = in_valid & in_ready & ch_ok;
    assign last    = (k == LAST_K);
    assign wr_next = wr_ptr[in_ch] + TAP_W'(1);
    assign rd_ptr  = wr_ptr[ch] - k;

    always_comb begin
        prod    = coef[k] * delay[ch][rd_ptr];
        mac_sum = acc + {{TAP_W{prod[PROD_W-1]}}, prod};
        rounded = mac_sum + HALF;
        shifted = rounded >>> OUT_SHIFT;
        // In range iff every bit from the output sign bit upward agrees.
        sat     = !((&shifted[ACC_W-1:DATA_W-1]) || !(|shifted[ACC_W-1:DATA_W-1]));
        if (sat) begin
            result = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            result = shifted[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coef <= '{default: '0};
        end else if (coef_we && in_ready) begin
            coef[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay  <= '{default: '0};
            wr_ptr <= '{default: '0};
        end else if (accept) begin
            wr_ptr[in_ch]         <= wr_next;
            delay[in_ch][wr_next] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch        <= '0;
            k         <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    ch  <= in_ch;
                    k   <= '0;
                    acc <= '0;
                end
            end else begin
                acc <= mac_sum;
                k   <= k + TAP_W'(1);
                if (last) begin
                    out_valid <= 1'b1;
                    out_ch    <= ch;
                    out_data  <= result;
                    out_sat   <= sat;
                end
            end
        end
    end

endmodule

// File: tb/tb_fir_tdm_mac.sv
// Directed bench for fir_tdm_mac: default-size instance plus a small CH=3/TAPS=4
// instance for out-of-range channel and rounding corners.
module tb_fir_tdm_mac;
    localparam int TAPS = 64;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               in_valid, in_ready, coef_we, out_valid, out_sat, busy;
    logic [0:0]         in_ch, out_ch;
    logic signed [15:0] in_data, coef_data, out_data;
    logic [5:0]         coef_addr;

    logic               t_in_valid, t_in_ready, t_coef_we, t_out_valid, t_out_sat, t_busy;
    logic [1:0]         t_in_ch, t_out_ch, t_coef_addr;
    logic signed [15:0] t_in_data, t_coef_data, t_out_data;

    int checks = 0;
    int errors = 0;

    fir_tdm_mac dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_ch(in_ch), .in_data(in_data), .coef_we(coef_we), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_valid(out_valid), .out_ch(out_ch),
        .out_data(out_data), .out_sat(out_sat), .busy(busy)
    );

    fir_tdm_mac #(.TAPS(4), .CH(3)) dut3 (
        .clk(clk), .reset(reset), .in_valid(t_in_valid), .in_ready(t_in_ready),
        .in_ch(t_in_ch), .in_data(t_in_data), .coef_we(t_coef_we), .coef_addr(t_coef_addr),
        .coef_data(t_coef_data), .out_valid(t_out_valid), .out_ch(t_out_ch),
        .out_data(t_out_data), .out_sat(t_out_sat), .busy(t_busy)
    );

    typedef struct {
        int ch;
        int data;
        int exp_data;
        int exp_ch;
        int exp_sat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_rst(input string tag);
        check({tag, " in_ready"},  int'(in_ready),  1);
        check({tag, " busy"},      int'(busy),      0);
        check({tag, " out_valid"}, int'(out_valid), 0);
        check({tag, " out_data"},  int'(out_data),  0);
        check({tag, " out_ch"},    int'(out_ch),    0);
        check({tag, " out_sat"},   int'(out_sat),   0);
    endtask

    task automatic wr_coef(input int a, input int val);
        coef_we   = 1'b1;
        coef_addr = a[5:0];
        coef_data = val[15:0];
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    // Offer one sample, then wait for its result; lat counts edges from accept to out_valid.
    task automatic send(input int c, input int d, output int od, output int oc,
                        output int os, output int lat);
        int n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        in_valid = 1'b1;
        in_ch    = c[0:0];
        in_data  = d[15:0];
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 300) begin @(negedge clk); lat++; end
        od = out_data;
        oc = int'(out_ch);
        os = int'(out_sat);
    endtask

    task automatic send3(input int c, input int d, output int od, output int oc,
                         output int os, output int lat);
        int n = 0;
        while (!t_in_ready && n < 50) begin @(negedge clk); n++; end
        t_in_valid = 1'b1;
        t_in_ch    = c[1:0];
        t_in_data  = d[15:0];
        @(negedge clk);
        t_in_valid = 1'b0;
        lat = 0;
        while (!t_out_valid && lat < 50) begin @(negedge clk); lat++; end
        od = t_out_data;
        oc = int'(t_out_ch);
        os = int'(t_out_sat);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int od, oc, os, lat, cnt, n_acc, n_out;
        int acc_edge[4];
        int out_edge[4];
        int out_val[4];

        reset = 1'b1;
        in_valid = 1'b0; in_ch = '0; in_data = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        t_in_valid = 1'b0; t_in_ch = '0; t_in_data = '0;
        t_coef_we = 1'b0; t_coef_addr = '0; t_coef_data = '0;
        repeat (2) @(negedge clk);
        check_rst("por");
        reset = 1'b0;
        @(negedge clk);
        check("por released in_ready", int'(in_ready), 1);

        // Small instance: b[0]=0.5, others 0.
        t_coef_we = 1'b1; t_coef_addr = 2'd0; t_coef_data = 16'sd16384;
        @(negedge clk);
        t_coef_we = 1'b0;
        t_in_valid = 1'b1; t_in_ch = 2'd3; t_in_data = 16'sd1001;
        @(negedge clk);
        t_in_valid = 1'b0;
        check("ch3 discard in_ready", int'(t_in_ready), 1);
        cnt = 0;
        repeat (10) begin @(negedge clk); if (t_out_valid) cnt++; end
        check("ch3 discard out_valid count", cnt, 0);
        send3(2, 1001, od, oc, os, lat);
        check("round up 1001*0.5", od, 501);
        check("round up out_ch", oc, 2);
        check("round up out_sat", os, 0);
        check("small latency", lat, 4);
        send3(2, -1001, od, oc, os, lat);
        check("round neg -1001*0.5", od, -500);
        send3(1, 3, od, oc, os, lat);
        check("round 3*0.5", od, 2);
        check("round 3*0.5 out_ch", oc, 1);

        // Main instance: impulse on ch0, then ch0 impulse interleaved with ch1 zeros.
        for (int i = 0; i < TAPS; i++) wr_coef(i, i + 1);
        for (int i = 0; i <= TAPS; i++) begin
            v.ch = 0; v.data = (i == 0) ? 32767 : 0;
            v.exp_data = (i < TAPS) ? i + 1 : 0; v.exp_ch = 0; v.exp_sat = 0;
            vecs.push_back(v);
        end
        for (int i = 0; i <= TAPS; i++) begin
            v.ch = 0; v.data = (i == 0) ? 32767 : 0;
            v.exp_data = (i < TAPS) ? i + 1 : 0; v.exp_ch = 0; v.exp_sat = 0;
            vecs.push_back(v);
            v.ch = 1; v.data = 0; v.exp_data = 0; v.exp_ch = 1; v.exp_sat = 0;
            vecs.push_back(v);
        end
        foreach (vecs[i]) begin
            send(vecs[i].ch, vecs[i].data, od, oc, os, lat);
            check($sformatf("vec%0d out_data", i), od, vecs[i].exp_data);
            check($sformatf("vec%0d out_ch", i), oc, vecs[i].exp_ch);
            check($sformatf("vec%0d out_sat", i), os, vecs[i].exp_sat);
            check($sformatf("vec%0d latency", i), lat, TAPS);
        end

        // Saturation in both directions, plus output hold between results.
        for (int i = 0; i < TAPS; i++) wr_coef(i, 32767);
        for (int i = 0; i < TAPS; i++) send(0, 32767, od, oc, os, lat);
        check("sat pos out_data", od, 32767);
        check("sat pos out_sat", os, 1);
        repeat (3) @(negedge clk);
        check("hold out_valid low", int'(out_valid), 0);
        check("hold out_data", int'(out_data), 32767);
        check("hold out_sat", int'(out_sat), 1);
        for (int i = 0; i < TAPS; i++) send(0, -32768, od, oc, os, lat);
        check("sat neg out_data", od, -32768);
        check("sat neg out_sat", os, 1);

        // Held in_valid: accept spacing, latency, and a dropped coefficient write while busy.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < TAPS; i++) wr_coef(i, i + 1);
        in_ch = 1'b0; in_data = 16'sd32767; in_valid = 1'b1;
        n_acc = 0; n_out = 0;
        for (int cyc = 1; cyc <= 3 * (TAPS + 1) + 1; cyc++) begin
            if (in_ready && n_acc < 4) begin acc_edge[n_acc] = cyc; n_acc++; end
            if (cyc == 10) begin
                coef_we = 1'b1; coef_addr = 6'd0; coef_data = 16'sd32767;
            end else begin
                coef_we = 1'b0;
            end
            @(negedge clk);
            if (out_valid && n_out < 4) begin
                out_edge[n_out] = cyc; out_val[n_out] = out_data; n_out++;
            end
        end
        in_valid = 1'b0;
        check("held accept count", n_acc, 4);
        check("held result count", n_out, 3);
        if (n_acc >= 3 && n_out >= 3) begin
            check("accept interval 1", acc_edge[1] - acc_edge[0], TAPS + 1);
            check("accept interval 2", acc_edge[2] - acc_edge[1], TAPS + 1);
            for (int i = 0; i < 3; i++)
                check($sformatf("held latency %0d", i), out_edge[i] - acc_edge[i], TAPS);
            check("held out 0", out_val[0], 1);
            check("held out 1 (busy write dropped)", out_val[1], 3);
            check("held out 2", out_val[2], 6);
        end

        // Reset 30 cycles into a pass.
        cnt = 0;
        while (!in_ready && cnt < 200) begin @(negedge clk); cnt++; end
        check("drain in_ready", int'(in_ready), 1);
        in_valid = 1'b1; in_ch = 1'b0; in_data = 16'sd32767;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (29) @(negedge clk);
        check("midmac busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1 check_rst("midmac");
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (80) begin @(negedge clk); if (out_valid) cnt++; end
        check("aborted pass out_valid count", cnt, 0);
        check("after reset in_ready", int'(in_ready), 1);
        for (int i = 0; i < TAPS; i++) wr_coef(i, i + 1);
        send(0, 32767, od, oc, os, lat);
        check("post reset impulse 0", od, 1);
        check("post reset latency", lat, TAPS);
        send(0, 0, od, oc, os, lat);
        check("post reset impulse 1", od, 2);
        send(0, 0, od, oc, os, lat);
        check("post reset impulse 2", od, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
